// File: rtl/computer_system_clkgen_pkg.sv
// Shared types and constants for the divided-clock generator.
package computer_system_clkgen_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } clkgen_state_e;

  localparam int MIN_DIV  = 2;
  localparam int MIN_HIGH = 1;
  localparam int CH_W     = 3;

endpackage

// File: rtl/computer_system_clkgen_chan.sv
// One output channel: clamped shadow configuration, run counter and registered divided clock.
module computer_system_clkgen_chan
  import computer_system_clkgen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEF_DIV   = 4,
  parameter int DEF_HIGH  = 2,
  parameter int DEF_PHASE = 0
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             outclk
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [3*CNT_W-1:0] clamp(input logic [CNT_W-1:0] d_in,
                                                input logic [CNT_W-1:0] h_in,
                                                input logic [CNT_W-1:0] p_in);
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] p;
    d = (d_in < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d_in;
    if (h_in < CNT_W'(MIN_HIGH)) h = CNT_W'(MIN_HIGH);
    else if (h_in >= d)          h = d - ONE;
    else                         h = h_in;
    p = (p_in >= d) ? d - ONE : p_in;
    return {d, h, p};
  endfunction

  localparam logic [3*CNT_W-1:0] DEF_CFG =
    clamp(CNT_W'(DEF_DIV), CNT_W'(DEF_HIGH), CNT_W'(DEF_PHASE));

  logic [CNT_W-1:0]   div_q;
  logic [CNT_W-1:0]   high_q;
  logic [CNT_W-1:0]   phase_q;
  logic [CNT_W-1:0]   cnt;
  logic [3*CNT_W-1:0] wr_cfg;

  assign wr_cfg = clamp(cfg_div, cfg_high, cfg_phase);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      {div_q, high_q, phase_q} <= DEF_CFG;
      cnt    <= '0;
      outclk <= 1'b0;
    end else begin
      if (wr) {div_q, high_q, phase_q} <= wr_cfg;
      // Preloading div-phase delays the first high phase by exactly phase_q cycles.
      if (load)     cnt <= (phase_q == '0) ? '0 : div_q - phase_q;
      else if (run) cnt <= (cnt == div_q - ONE) ? '0 : cnt + ONE;
      outclk <= run && (cnt < high_q);
    end
  end

endmodule

// File: rtl/computer_system_clk_div_gen.sv
// Multi-channel programmable clock divider with settle/lock sequencing and config write port.
//   state  | meaning
//   SETTLE | outputs held low, settle counter running toward lock
//   LOCKED | all channels aligned and running, locked = 1
module computer_system_clk_div_gen
  import computer_system_clkgen_pkg::*;
#(
  parameter int NUM_CLK     = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 4,
  parameter int DEF_HIGH    = 2,
  parameter int DEF_PHASE   = 0
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_phase,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic [NUM_CLK-1:0] outclk,
  output logic               locked
);

  localparam int              SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

  clkgen_state_e    state;
  logic [SET_W-1:0] settle_cnt;
  logic             ch_ok;
  logic             accept;
  logic             reject;
  logic             expire;
  logic             run;

  assign ch_ok  = int'(cfg_ch) < NUM_CLK;
  assign accept = cfg_wr && ch_ok;
  assign reject = cfg_wr && !ch_ok;
  // An accepted write wins over settle expiry and kills running outputs on the same edge.
  assign expire = (state == SETTLE) && (settle_cnt == SET_LAST) && !accept;
  assign run    = (state == LOCKED) && !accept;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_ack <= accept;
      cfg_err <= reject;
      if (accept) begin
        state      <= SETTLE;
        settle_cnt <= '0;
        locked     <= 1'b0;
      end else if (state == SETTLE) begin
        if (settle_cnt == SET_LAST) begin
          state      <= LOCKED;
          settle_cnt <= '0;
          locked     <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
    computer_system_clkgen_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH),
      .DEF_PHASE(DEF_PHASE)
    ) u_chan (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .wr       (accept && (cfg_ch == CH_W'(i))),
      .load     (expire),
      .run      (run),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .cfg_phase(cfg_phase),
      .outclk   (outclk[i])
    );
  end

endmodule

// File: tb/tb_computer_system_clk_div_gen.sv
// Directed and random checks of the clock generator against a phase-arithmetic reference model.
module tb_computer_system_clk_div_gen;

  localparam int NUM_CLK = 2;
  localparam int CNT_W   = 16;
  localparam int LOCK    = 16;

  logic               refclk = 1'b0;
  logic               rst_n;
  logic               cfg_wr;
  logic [2:0]         cfg_ch;
  logic [CNT_W-1:0]   cfg_div;
  logic [CNT_W-1:0]   cfg_high;
  logic [CNT_W-1:0]   cfg_phase;
  logic               cfg_ack;
  logic               cfg_err;
  logic [NUM_CLK-1:0] outclk;
  logic               locked;

  int total = 0;
  int bad   = 0;

  // Model: effective per-channel settings, edges since reset release, edge of last restart.
  int m_div  [NUM_CLK];
  int m_high [NUM_CLK];
  int m_phase[NUM_CLK];
  int edge_n;
  int last_event;
  bit exp_ack;
  bit exp_err;

  computer_system_clk_div_gen #(
    .NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK),
    .DEF_DIV(4), .DEF_HIGH(2), .DEF_PHASE(0)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_phase(cfg_phase),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic set_cfg(input int ch, input int d, input int h, input int p);
    int ed;
    ed = (d < 2) ? 2 : d;
    m_div[ch]   = ed;
    m_high[ch]  = (h == 0) ? 1 : ((h > ed - 1) ? ed - 1 : h);
    m_phase[ch] = (p > ed - 1) ? ed - 1 : p;
  endtask

  function automatic bit exp_locked();
    return rst_n && (edge_n - last_event >= LOCK);
  endfunction

  // Channel runs as a clock of period div, delayed by phase, starting one edge after lock.
  function automatic bit exp_clk(input int ch);
    int j;
    int pos;
    if (!exp_locked()) return 1'b0;
    j = edge_n - last_event - LOCK;
    if (j < 1) return 1'b0;
    pos = (((j - 1 - m_phase[ch]) % m_div[ch]) + m_div[ch]) % m_div[ch];
    return pos < m_high[ch];
  endfunction

  task automatic check_all(input string tag);
    logic [NUM_CLK-1:0] eclk;
    bit el;
    for (int c = 0; c < NUM_CLK; c++) eclk[c] = exp_clk(c);
    el = exp_locked();
    total++;
    assert (locked === el) else begin
      bad++; $error("FAIL %s.locked edge=%0d observed=%0b expected=%0b", tag, edge_n, locked, el);
    end
    total++;
    assert (cfg_ack === exp_ack) else begin
      bad++; $error("FAIL %s.cfg_ack edge=%0d observed=%0b expected=%0b", tag, edge_n, cfg_ack, exp_ack);
    end
    total++;
    assert (cfg_err === exp_err) else begin
      bad++; $error("FAIL %s.cfg_err edge=%0d observed=%0b expected=%0b", tag, edge_n, cfg_err, exp_err);
    end
    total++;
    assert (outclk === eclk) else begin
      bad++; $error("FAIL %s.outclk edge=%0d observed=%b expected=%b", tag, edge_n, outclk, eclk);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge refclk);
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (rst_n) begin
      edge_n++;
      if (cfg_wr) begin
        if (int'(cfg_ch) < NUM_CLK) begin
          set_cfg(int'(cfg_ch), int'(cfg_div), int'(cfg_high), int'(cfg_phase));
          last_event = edge_n;
          exp_ack    = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_write(input string tag, input int ch, input int d, input int h, input int p);
    cfg_ch    = 3'(ch);
    cfg_div   = CNT_W'(d);
    cfg_high  = CNT_W'(h);
    cfg_phase = CNT_W'(p);
    cfg_wr    = 1'b1;
    tick(tag);
    cfg_wr    = 1'b0;
  endtask

  // Asserts reset away from the clock edge, optionally with a write pending that must be dropped.
  task automatic hard_reset(input string tag, input bit with_write);
    cfg_ch    = 3'd1;
    cfg_div   = CNT_W'(9);
    cfg_high  = CNT_W'(5);
    cfg_phase = CNT_W'(3);
    cfg_wr    = with_write;
    rst_n     = 1'b0;
    for (int c = 0; c < NUM_CLK; c++) set_cfg(c, 4, 2, 0);
    exp_ack = 1'b0;
    exp_err = 1'b0;
    #1;
    check_all({tag, ".async"});
    tick(tag);
    cfg_wr = 1'b0;
    tick(tag);
    @(negedge refclk);
    rst_n      = 1'b1;
    edge_n     = 0;
    last_event = 0;
  endtask

  initial begin
    cfg_wr = 1'b0;
    edge_n = 0;
    last_event = 0;

    hard_reset("por", 1'b0);
    run_n("defaults", 30);

    do_write("wr_ch1", 1, 10, 3, 4);
    run_n("relock_ch1", 35);

    do_write("clamp", 0, 1, 0, 7);
    run_n("clamp_run", 25);

    do_write("bad_ch", 5, 3, 1, 1);
    run_n("bad_ch_run", 10);

    do_write("settle_a", 0, 6, 3, 0);
    run_n("settle_gap", 9);
    do_write("settle_b", 1, 8, 5, 2);
    run_n("settle_ext", 30);

    do_write("expiry_a", 0, 5, 2, 1);
    run_n("expiry_gap", 15);
    do_write("expiry_b", 1, 7, 3, 6);
    run_n("expiry_run", 30);

    do_write("pre_rst", 1, 12, 6, 5);
    run_n("mid_settle", 5);
    hard_reset("rst_settle", 1'b1);
    run_n("after_rst_settle", 25);

    hard_reset("rst_locked", 1'b1);
    run_n("after_rst_locked", 20);

    for (int k = 0; k < 40; k++) begin
      run_n("rnd_idle", $urandom_range(0, 40));
      do_write("rnd_wr", $urandom_range(0, 7), $urandom_range(0, 12),
               $urandom_range(0, 13), $urandom_range(0, 13));
    end
    run_n("rnd_tail", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/computer_system_clk_div_gen.md
COMPUTER_SYSTEM_CLK_DIV_GEN -- requirements
Module: computer_system_clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CLK, default 2, number of output clock channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the divide, high-time and phase fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, number of refclk cycles spent in SETTLE before lock (legal ≥1).
REQ-004 SHALL have parameters DEF_DIV, DEF_HIGH and DEF_PHASE, defaults 4, 2 and 0, the reset configuration applied to every channel.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_wr, input, 1 bit: one-cycle configuration write strobe.
REQ-008 SHALL have port cfg_ch, input, 3 bits: target channel index for a write.
REQ-009 SHALL have ports cfg_div, cfg_high and cfg_phase, input, CNT_W bits each: period, high time and phase delay, all in refclk cycles.
REQ-010 SHALL have port cfg_ack, output, 1 bit: one-cycle pulse when a write is accepted.
REQ-011 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-012 SHALL have port outclk, output, NUM_CLK bits: the divided clocks, registered.
REQ-013 SHALL have port locked, output, 1 bit: high while all outputs are aligned and running.

Function
REQ-014 SHALL implement a controller FSM with states SETTLE and LOCKED.
REQ-015 SHALL keep, per channel, shadow registers div_q, high_q and phase_q plus a run counter cnt.
REQ-016 SHALL clamp values when a write is accepted:
- div < 2 becomes 2.
- high = 0 becomes 1; high ≥ div becomes div-1.
- phase ≥ div becomes div-1.
REQ-017 SHALL handle the end of SETTLE as follows:
- A settle counter counts 0..LOCK_CYCLES-1.
- On the edge where it reaches LOCK_CYCLES-1, the state becomes LOCKED and locked goes to 1.
- On that same edge, every channel loads cnt = (phase_q==0) ? 0 : div_q-phase_q.
REQ-018 SHALL, in LOCKED, advance cnt by one each cycle and wrap from div_q-1 to 0.
REQ-019 SHALL register outclk[ch] as (cnt < high_q), giving a first rising edge exactly phase_q+1 cycles after the lock edge.
REQ-020 SHALL force outclk to 0 while in SETTLE, and hold cnt there.
REQ-021 SHALL treat cfg_wr with cfg_ch < NUM_CLK in LOCKED as follows:
- Update the shadow registers.
- Pulse cfg_ack on the next cycle.
- Go to SETTLE with the settle counter at 0.
- Drop locked and all outclk on the next edge.
REQ-022 SHALL treat cfg_wr in SETTLE as follows:
- Update the shadow registers.
- Pulse cfg_ack.
- Restart the settle counter at 0, extending SETTLE.
REQ-023 SHALL handle cfg_ch ≥ NUM_CLK by pulsing cfg_err on the next cycle, with no state, shadow or output change.
REQ-024 SHALL give cfg_wr priority when it coincides with settle-counter expiry: the counter restarts and the state stays SETTLE.
REQ-025 SHALL not make cfg_ack and cfg_err depend on the FSM state; write-to-ack latency is exactly 1 cycle.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously set:
- state = SETTLE, settle counter = 0, cnt = 0.
- outclk = 0, locked = 0, cfg_ack = 0, cfg_err = 0.
- Shadow registers = clamped DEF_DIV, DEF_HIGH and DEF_PHASE.
REQ-027 SHALL, after rst_n rises, reach locked = 1 exactly LOCK_CYCLES refclk edges later.
REQ-028 SHALL apply full reset on rst_n assertion in any state or mid-write; a cfg_wr in the assertion cycle is discarded.

Structure
REQ-029 SHALL place the following in package computer_system_clkgen_pkg:
- The FSM state type.
- Constants MIN_DIV = 2 and MIN_HIGH = 1.
- The channel-index width (3).
REQ-030 SHALL put the per-channel shadow, cnt and outclk logic in sub-module computer_system_clkgen_chan, instantiated NUM_CLK times; the FSM and config decode stay in the top.
REQ-031 SHALL use only the refclk domain, with no clock gating and no combinational paths to outputs.

Verification
REQ-032 SHALL cover reset release with defaults (NUM_CLK=2, LOCK_CYCLES=16): locked rises 16 edges after rst_n rises, then both outclk run period 4, high 2, in phase.
REQ-033 SHALL cover a write to ch1 of div=10, high=3, phase=4: cfg_ack at +1, locked=0 at +1, relock 16 cycles later, and outclk[1] rises 4 cycles after outclk[0].
REQ-034 SHALL cover clamping: writing div=1, high=0, phase=7 gives an effective period 2, high 1, phase 1.
REQ-035 SHALL cover a write with cfg_ch=5 while NUM_CLK=2: cfg_err pulses once, locked stays 1, and the outclk waveform is unchanged.
REQ-036 SHALL cover a second write issued 10 cycles into SETTLE: locked is delayed to 16 cycles after the second write.
REQ-037 SHALL cover rst_n asserted mid-SETTLE and mid-LOCKED: all outputs go 0 immediately and the shadow registers return to their defaults.
